// File: rtl/frog_pkg.sv
// Shared definitions for the per-player frog position controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: lane width, start/goal one-hot constants, FSM state encoding.
package frog_pkg;

    // Width of the one-hot lane vector: bit 0 is the start lane, top bit the goal.
    localparam int FROG_W = 19;

    localparam logic [FROG_W-1:0] FROG_START = FROG_W'(1);
    localparam logic [FROG_W-1:0] FROG_GOAL  = FROG_START << (FROG_W - 1);

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_DEAD = 2'd1,
        ST_WIN  = 2'd2
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability debouncer, rising-edge pulse.
// Latency: raw level change to press pulse is 2 + DB_CYCLES cycles.
// Backpressure: none; the press pulse is a single cycle and is not held.
//
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_raw   : raw button level, asynchronous to i_clk
//   o_press : one-cycle pulse on a debounced rising edge (releases give nothing)
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_press
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic             r_db_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            // The counter tracks consecutive cycles where the synchronized level
            // disagrees with the accepted level; any agreeing cycle restarts it.
            if (r_sync2 != r_db) begin
                if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_db & ~r_db_d;

endmodule

// File: rtl/frog_ctrl.sv
// Per-player frog position controller: debounced go/back moves, hit respawn, goal freeze.
// Latency: raw button high to frog update is 2 + DB_CYCLES + 1 cycles; hit to respawn is 1 cycle.
// Backpressure: none; presses arriving while dead or after winning are dropped.
//
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   go/back : raw active-high push buttons, asynchronous to clk
//   hit     : collision level from the game top (frog AND block pattern)
//   frog    : one-hot frog position, bit 0 = start, top bit = goal
//   at_goal : high while the frog sits on the goal bit (sticky until reset)
//   dead    : high for the respawn hold-off after a hit
//   moved   : one-cycle pulse for each button-caused position change
module frog_ctrl
    import frog_pkg::*;
#(
    parameter int DB_CYCLES      = 500000,
    parameter int RESPAWN_CYCLES = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              back,
    input  logic              hit,
    output logic [FROG_W-1:0] frog,
    output logic              at_goal,
    output logic              dead,
    output logic              moved
);

    // A hold-off of one cycle still needs a 1-bit counter register.
    localparam int RSP_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

    logic              w_go_press;
    logic              w_back_press;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FROG_W-1:0] r_frog;
    logic [FROG_W-1:0] w_frog_nxt;
    logic [RSP_W-1:0]  r_rsp_cnt;
    logic [RSP_W-1:0]  w_rsp_cnt_nxt;
    logic              r_dead;
    logic              w_dead_nxt;
    logic              r_at_goal;
    logic              w_at_goal_nxt;
    logic              r_moved;
    logic              w_moved_nxt;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_go (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_raw   (go),
        .o_press (w_go_press)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_back (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_raw   (back),
        .o_press (w_back_press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_PLAY;
            r_frog    <= FROG_START;
            r_rsp_cnt <= '0;
            r_dead    <= 1'b0;
            r_at_goal <= 1'b0;
            r_moved   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_frog    <= w_frog_nxt;
            r_rsp_cnt <= w_rsp_cnt_nxt;
            r_dead    <= w_dead_nxt;
            r_at_goal <= w_at_goal_nxt;
            r_moved   <= w_moved_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frog_nxt    = r_frog;
        w_rsp_cnt_nxt = r_rsp_cnt;
        w_dead_nxt    = r_dead;
        w_at_goal_nxt = r_at_goal;
        w_moved_nxt   = 1'b0;

        case (r_state)
            ST_PLAY: begin
                if (hit) begin
                    // A hit wins over any press landing in the same cycle.
                    w_frog_nxt    = FROG_START;
                    w_dead_nxt    = 1'b1;
                    w_rsp_cnt_nxt = RSP_W'(RESPAWN_CYCLES - 1);
                    w_state_nxt   = ST_DEAD;
                end else if (w_go_press && !w_back_press) begin
                    // Entering WIN on the top bit guarantees the next shift never
                    // happens, so the vector can not be emptied.
                    w_frog_nxt  = r_frog << 1;
                    w_moved_nxt = 1'b1;
                    if (w_frog_nxt[FROG_W-1]) begin
                        w_at_goal_nxt = 1'b1;
                        w_state_nxt   = ST_WIN;
                    end
                end else if (w_back_press && !w_go_press && !r_frog[0]) begin
                    // Back on the start lane saturates silently.
                    w_frog_nxt  = r_frog >> 1;
                    w_moved_nxt = 1'b1;
                end
            end

            ST_DEAD: begin
                // The start lane is never blocked, so hit is ignored here.
                w_frog_nxt = FROG_START;
                if (r_rsp_cnt == '0) begin
                    w_dead_nxt  = 1'b0;
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_rsp_cnt_nxt = r_rsp_cnt - RSP_W'(1);
                end
            end

            ST_WIN: begin
                w_frog_nxt    = FROG_GOAL;
                w_at_goal_nxt = 1'b1;
            end

            default: begin
                w_frog_nxt  = FROG_START;
                w_state_nxt = ST_PLAY;
            end
        endcase
    end

    assign frog    = r_frog;
    assign at_goal = r_at_goal;
    assign dead    = r_dead;
    assign moved   = r_moved;

endmodule
